// File: rtl/clangpu_pkg.sv
// Shared definitions for the core's AXI read path: fixed AXI encodings and the
// read-arbiter state type.
package clangpu_pkg;

   localparam logic [2:0] AXI_SIZE_4B       = 3'b010;
   localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
   localparam logic [3:0] AXI_CACHE_BUF_MOD = 4'b0011;
   localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      AR   = 2'd1,
      R    = 2'd2,
      RSP  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/axi_rd_arbiter_rr.sv
// Two-way round-robin pick. When both ports request, the one not served last
// wins; a lone requester always wins. Purely combinational; the caller registers.
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant,
   output logic       any
);

   // Port 1 wins when it is alone, or when both ask and port 0 was served last
   always_comb begin
      any   = |req;
      grant = req[1] & (~req[0] | ~last_grant);
   end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read master between instruction fetch (port 0) and data
// load (port 1). One single-beat transaction in flight at a time; the winner's
// index travels on ARID and the returned beat is routed back to that port.
module axi_rd_arbiter
   import clangpu_pkg::*;
#(
   parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
   parameter int C_M_AXI_ADDR_WIDTH      = 32,
   parameter int C_M_AXI_DATA_WIDTH      = 32,
   parameter int C_M_AXI_ARUSER_WIDTH    = 1,
   parameter int C_M_AXI_RUSER_WIDTH     = 4
) (
   input  logic                               ACLK,
   input  logic                               ARESETN,
   input  logic                               REQ0_VALID,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]      REQ0_ADDR,
   output logic                               REQ0_ACK,
   input  logic                               REQ1_VALID,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]      REQ1_ADDR,
   output logic                               REQ1_ACK,
   output logic                               RSP0_VALID,
   output logic [C_M_AXI_DATA_WIDTH-1:0]      RSP0_DATA,
   output logic                               RSP0_ERR,
   output logic                               RSP1_VALID,
   output logic [C_M_AXI_DATA_WIDTH-1:0]      RSP1_DATA,
   output logic                               RSP1_ERR,
   output logic                               BUSY,
   output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_ARID,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_ARADDR,
   output logic [7:0]                         M_AXI_ARLEN,
   output logic [2:0]                         M_AXI_ARSIZE,
   output logic [1:0]                         M_AXI_ARBURST,
   output logic                               M_AXI_ARLOCK,
   output logic [3:0]                         M_AXI_ARCACHE,
   output logic [2:0]                         M_AXI_ARPROT,
   output logic [3:0]                         M_AXI_ARQOS,
   output logic [C_M_AXI_ARUSER_WIDTH-1:0]    M_AXI_ARUSER,
   output logic                               M_AXI_ARVALID,
   input  logic                               M_AXI_ARREADY,
   input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_RID,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_RDATA,
   input  logic [1:0]                         M_AXI_RRESP,
   input  logic                               M_AXI_RLAST,
   input  logic [C_M_AXI_RUSER_WIDTH-1:0]     M_AXI_RUSER,
   input  logic                               M_AXI_RVALID,
   output logic                               M_AXI_RREADY
);

   localparam int IDW = C_M_AXI_THREAD_ID_WIDTH;
   localparam int AW  = C_M_AXI_ADDR_WIDTH;
   localparam int DW  = C_M_AXI_DATA_WIDTH;

   arb_state_t    state, state_nxt;
   logic          arb_grant, arb_any;
   logic          grant_r, last_grant_r;
   logic [AW-1:0] araddr_r;
   logic [IDW-1:0] arid_r;
   logic [1:0]    ack_r;
   logic [DW-1:0] rsp_data0_r, rsp_data1_r;
   logic          rsp_err0_r, rsp_err1_r;
   logic          latch_req, ar_hs, r_hs, beat_err;
   logic          unused_bits;

   rr_arbiter2 u_rr (
      .req        ({REQ1_VALID, REQ0_VALID}),
      .last_grant (last_grant_r),
      .grant      (arb_grant),
      .any        (arb_any)
   );

   // State register; reset abandons any beat in flight
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) state <= IDLE;
      else          state <= state_nxt;
   end

   // Next state plus the AR/R handshake strobes, decoded straight from state
   always_comb begin
      state_nxt     = state;
      latch_req     = 1'b0;
      ar_hs         = 1'b0;
      r_hs          = 1'b0;
      M_AXI_ARVALID = 1'b0;
      M_AXI_RREADY  = 1'b0;
      case (state)
         IDLE: begin
            if (arb_any) begin
               latch_req = 1'b1;
               state_nxt = AR;
            end
         end
         AR: begin
            M_AXI_ARVALID = 1'b1;
            if (M_AXI_ARREADY) begin
               ar_hs     = 1'b1;
               state_nxt = R;
            end
         end
         R: begin
            M_AXI_RREADY = 1'b1;
            if (M_AXI_RVALID) begin
               r_hs      = 1'b1;
               state_nxt = RSP;
            end
         end
         RSP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Latch the winner, its word-aligned address and the one-cycle ACK;
   // round-robin history only advances once the slave has accepted the address
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         grant_r      <= 1'b0;
         last_grant_r <= 1'b1;
         araddr_r     <= '0;
         arid_r       <= '0;
         ack_r        <= 2'b00;
      end else begin
         ack_r <= 2'b00;
         if (latch_req) begin
            grant_r  <= arb_grant;
            araddr_r <= {(arb_grant ? REQ1_ADDR[AW-1:2] : REQ0_ADDR[AW-1:2]), 2'b00};
            arid_r   <= IDW'(arb_grant);
            ack_r    <= arb_grant ? 2'b10 : 2'b01;
         end
         if (ar_hs) last_grant_r <= grant_r;
      end
   end

   // Any bad response code, a missing RLAST or a foreign RID marks the beat bad
   assign beat_err = (M_AXI_RRESP != AXI_RESP_OKAY) | ~M_AXI_RLAST | (M_AXI_RID != arid_r);

   // Capture the beat into the granted port; the other port keeps its last result
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         rsp_data0_r <= '0;
         rsp_data1_r <= '0;
         rsp_err0_r  <= 1'b0;
         rsp_err1_r  <= 1'b0;
      end else if (r_hs) begin
         if (grant_r) begin
            rsp_data1_r <= M_AXI_RDATA;
            rsp_err1_r  <= beat_err;
         end else begin
            rsp_data0_r <= M_AXI_RDATA;
            rsp_err0_r  <= beat_err;
         end
      end
   end

   assign REQ0_ACK   = ack_r[0];
   assign REQ1_ACK   = ack_r[1];
   assign RSP0_VALID = (state == RSP) && !grant_r;
   assign RSP1_VALID = (state == RSP) &&  grant_r;
   assign RSP0_DATA  = rsp_data0_r;
   assign RSP1_DATA  = rsp_data1_r;
   assign RSP0_ERR   = rsp_err0_r;
   assign RSP1_ERR   = rsp_err1_r;
   assign BUSY       = (state != IDLE);

   assign M_AXI_ARID    = arid_r;
   assign M_AXI_ARADDR  = araddr_r;
   assign M_AXI_ARLEN   = 8'd0;
   assign M_AXI_ARSIZE  = AXI_SIZE_4B;
   assign M_AXI_ARBURST = AXI_BURST_INCR;
   assign M_AXI_ARLOCK  = 1'b0;
   assign M_AXI_ARCACHE = AXI_CACHE_BUF_MOD;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_ARQOS   = 4'b0000;
   assign M_AXI_ARUSER  = '0;

   // Address byte-offset bits and RUSER carry nothing this block needs
   assign unused_bits = ^{REQ0_ADDR[1:0], REQ1_ADDR[1:0], M_AXI_RUSER};

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: the bench acts as both requesters and the AXI slave.
module tb_axi_rd_arbiter;

   localparam int IDW = 1;
   localparam int AW  = 32;
   localparam int DW  = 32;

   logic           ACLK = 1'b0;
   logic           ARESETN;
   logic           REQ0_VALID, REQ1_VALID;
   logic [AW-1:0]  REQ0_ADDR, REQ1_ADDR;
   logic           REQ0_ACK, REQ1_ACK;
   logic           RSP0_VALID, RSP1_VALID;
   logic [DW-1:0]  RSP0_DATA, RSP1_DATA;
   logic           RSP0_ERR, RSP1_ERR;
   logic           BUSY;
   logic [IDW-1:0] M_AXI_ARID;
   logic [AW-1:0]  M_AXI_ARADDR;
   logic [7:0]     M_AXI_ARLEN;
   logic [2:0]     M_AXI_ARSIZE;
   logic [1:0]     M_AXI_ARBURST;
   logic           M_AXI_ARLOCK;
   logic [3:0]     M_AXI_ARCACHE;
   logic [2:0]     M_AXI_ARPROT;
   logic [3:0]     M_AXI_ARQOS;
   logic [0:0]     M_AXI_ARUSER;
   logic           M_AXI_ARVALID, M_AXI_ARREADY;
   logic [IDW-1:0] M_AXI_RID;
   logic [DW-1:0]  M_AXI_RDATA;
   logic [1:0]     M_AXI_RRESP;
   logic           M_AXI_RLAST;
   logic [3:0]     M_AXI_RUSER;
   logic           M_AXI_RVALID, M_AXI_RREADY;

   int tests = 0;
   int fails = 0;

   axi_rd_arbiter dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .REQ0_VALID(REQ0_VALID), .REQ0_ADDR(REQ0_ADDR), .REQ0_ACK(REQ0_ACK),
      .REQ1_VALID(REQ1_VALID), .REQ1_ADDR(REQ1_ADDR), .REQ1_ACK(REQ1_ACK),
      .RSP0_VALID(RSP0_VALID), .RSP0_DATA(RSP0_DATA), .RSP0_ERR(RSP0_ERR),
      .RSP1_VALID(RSP1_VALID), .RSP1_DATA(RSP1_DATA), .RSP1_ERR(RSP1_ERR),
      .BUSY(BUSY),
      .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
      .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARLOCK(M_AXI_ARLOCK),
      .M_AXI_ARCACHE(M_AXI_ARCACHE), .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARQOS(M_AXI_ARQOS),
      .M_AXI_ARUSER(M_AXI_ARUSER), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
      .M_AXI_RID(M_AXI_RID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
      .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RUSER(M_AXI_RUSER), .M_AXI_RVALID(M_AXI_RVALID),
      .M_AXI_RREADY(M_AXI_RREADY)
   );

   always #5 ACLK = ~ACLK;

   typedef struct {
      bit          r0, r1;
      logic [31:0] a0, a1;
      int          arw, rw;
      logic [31:0] rd;
      logic [1:0]  rr;
      bit          rl, rb;
   } txn_t;

   typedef struct {
      int          port;
      logic [31:0] addr;
      logic [31:0] data;
      bit          err;
      logic [31:0] d0, d1;
      int          lat;
      bit          ok;
   } res_t;

   typedef struct {
      txn_t        t;
      int          exp_port;
      logic [31:0] exp_addr;
      bit          exp_err;
   } vec_t;

   // Reference model state: who was served last and what each port last returned
   int          m_last;
   logic [31:0] m_data [2];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic int model_pick(input bit r0, input bit r1);
      if (r0 && r1) return 1 - m_last;
      return r1 ? 1 : 0;
   endfunction

   function automatic bit model_err(input txn_t t);
      return (t.rr != 2'b00) || !t.rl || t.rb;
   endfunction

   task automatic model_reset();
      m_last    = 1;
      m_data[0] = '0;
      m_data[1] = '0;
   endtask

   task automatic apply_reset();
      @(negedge ACLK);
      REQ0_VALID    = 1'b0;
      REQ1_VALID    = 1'b0;
      M_AXI_ARREADY = 1'b0;
      M_AXI_RVALID  = 1'b0;
      ARESETN       = 1'b0;
      @(negedge ACLK);
      @(negedge ACLK);
      ARESETN = 1'b1;
      model_reset();
   endtask

   // Run one complete transaction, playing the slave and watching the handshakes
   task automatic run_txn(input txn_t t, output res_t r);
      logic [31:0]    a_hold;
      logic [IDW-1:0] id_hold;
      int             k;
      r = '{port: -1, addr: '0, data: '0, err: 1'b0, d0: '0, d1: '0, lat: 0, ok: 1'b0};
      REQ0_VALID    = t.r0;
      REQ1_VALID    = t.r1;
      REQ0_ADDR     = t.a0;
      REQ1_ADDR     = t.a1;
      M_AXI_ARREADY = 1'b0;
      M_AXI_RVALID  = 1'b0;
      k = 0;
      do begin
         @(negedge ACLK);
         k++;
         if (!M_AXI_ARVALID)
            chk("idle_quiet", {RSP0_VALID, RSP1_VALID, M_AXI_RREADY}, 3'b000);
      end while (!M_AXI_ARVALID && k < 10);
      if (!M_AXI_ARVALID) begin
         chk("arvalid_timeout", M_AXI_ARVALID, 1);
         return;
      end
      r.lat   = k;
      r.port  = int'(M_AXI_ARID);
      r.addr  = M_AXI_ARADDR;
      a_hold  = M_AXI_ARADDR;
      id_hold = M_AXI_ARID;
      chk("ack", {REQ1_ACK, REQ0_ACK}, (r.port == 1) ? 2'b10 : 2'b01);
      for (int i = 0; i < t.arw; i++) begin
         @(negedge ACLK);
         chk("ar_hold", {M_AXI_ARVALID, M_AXI_RREADY, M_AXI_ARADDR == a_hold,
                         M_AXI_ARID == id_hold, REQ0_ACK, REQ1_ACK}, 6'b101100);
      end
      M_AXI_ARREADY = 1'b1;
      @(negedge ACLK);
      M_AXI_ARREADY = 1'b0;
      chk("r_enter", {M_AXI_ARVALID, M_AXI_RREADY, BUSY}, 3'b011);
      for (int i = 0; i < t.rw; i++) begin
         @(negedge ACLK);
         chk("r_wait", {M_AXI_ARVALID, M_AXI_RREADY, RSP0_VALID, RSP1_VALID}, 4'b0100);
      end
      M_AXI_RVALID = 1'b1;
      M_AXI_RDATA  = t.rd;
      M_AXI_RRESP  = t.rr;
      M_AXI_RLAST  = t.rl;
      M_AXI_RID    = id_hold ^ IDW'(t.rb);
      M_AXI_RUSER  = 4'($urandom);
      @(negedge ACLK);
      M_AXI_RVALID = 1'b0;
      M_AXI_RDATA  = $urandom;
      M_AXI_RLAST  = 1'b0;
      chk("rsp_state", {M_AXI_ARVALID, M_AXI_RREADY, RSP0_VALID, RSP1_VALID},
          (r.port == 1) ? 4'b0001 : 4'b0010);
      r.data = (r.port == 1) ? RSP1_DATA : RSP0_DATA;
      r.err  = (r.port == 1) ? RSP1_ERR  : RSP0_ERR;
      r.d0   = RSP0_DATA;
      r.d1   = RSP1_DATA;
      r.ok   = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      vec_t vecs [10];
      txn_t t;
      res_t r;
      int   k;

      REQ0_VALID = 0; REQ1_VALID = 0; REQ0_ADDR = '0; REQ1_ADDR = '0;
      M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RID = '0; M_AXI_RDATA = '0;
      M_AXI_RRESP = 2'b00; M_AXI_RLAST = 0; M_AXI_RUSER = '0;
      model_reset();

      // Reset values and constant AR fields
      ARESETN = 1'b0;
      #1;
      chk("reset_ctrl", {M_AXI_ARVALID, M_AXI_RREADY, REQ0_ACK, REQ1_ACK, RSP0_VALID,
                         RSP1_VALID, RSP0_ERR, RSP1_ERR, BUSY}, 9'd0);
      chk("reset_data", {RSP0_DATA, RSP1_DATA}, 64'd0);
      chk("reset_ar", {M_AXI_ARADDR, 31'd0, M_AXI_ARID}, 64'd0);
      chk("ar_const", {M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARLOCK, M_AXI_ARCACHE,
                       M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARUSER},
          {8'd0, 3'b010, 2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000, 1'b0});
      @(negedge ACLK);
      @(negedge ACLK);
      ARESETN = 1'b1;

      // Single read with latency check and one-cycle response pulse
      t = '{r0: 1, r1: 0, a0: 32'h1000_0006, a1: 32'h0, arw: 0, rw: 0,
            rd: 32'hDEAD_BEEF, rr: 2'b00, rl: 1, rb: 0};
      run_txn(t, r);
      chk("single_lat", r.lat, 1);
      chk("single_port", r.port, 0);
      chk("single_addr", r.addr, 32'h1000_0004);
      chk("single_data", r.data, 32'hDEAD_BEEF);
      chk("single_err", r.err, 0);
      REQ0_VALID = 1'b0;
      @(negedge ACLK);
      chk("single_pulse", {RSP0_VALID, RSP1_VALID, BUSY, RSP0_DATA},
          {3'b000, 32'hDEAD_BEEF});

      // Reset while ARVALID is high drops it immediately
      REQ1_VALID = 1'b1;
      REQ1_ADDR  = 32'h0000_0040;
      k = 0;
      do begin @(negedge ACLK); k++; end while (!M_AXI_ARVALID && k < 10);
      chk("pre_reset_arvalid", M_AXI_ARVALID, 1);
      ARESETN    = 1'b0;
      REQ1_VALID = 1'b0;
      #1;
      chk("async_reset", {M_AXI_ARVALID, M_AXI_RREADY, BUSY, REQ1_ACK, M_AXI_ARADDR},
          {4'b0000, 32'h0});
      @(negedge ACLK);
      ARESETN = 1'b1;
      model_reset();

      // Contention, stalls and error cases with hand-derived expectations
      vecs[0] = '{t: '{1, 1, 32'h100, 32'h204, 0, 0, 32'h1111_0000, 2'b00, 1, 0}, exp_port: 0, exp_addr: 32'h100, exp_err: 0};
      vecs[1] = '{t: '{1, 1, 32'h100, 32'h204, 0, 1, 32'h2222_0001, 2'b00, 1, 0}, exp_port: 1, exp_addr: 32'h204, exp_err: 0};
      vecs[2] = '{t: '{1, 1, 32'h10B, 32'h204, 1, 0, 32'h3333_0002, 2'b00, 1, 0}, exp_port: 0, exp_addr: 32'h108, exp_err: 0};
      vecs[3] = '{t: '{1, 1, 32'h10B, 32'h20F, 2, 2, 32'h4444_0003, 2'b00, 1, 0}, exp_port: 1, exp_addr: 32'h20C, exp_err: 0};
      vecs[4] = '{t: '{0, 1, 32'h0, 32'h300, 0, 0, 32'h5555_0004, 2'b10, 1, 0}, exp_port: 1, exp_addr: 32'h300, exp_err: 1};
      vecs[5] = '{t: '{0, 1, 32'h0, 32'h304, 0, 0, 32'h6666_0005, 2'b00, 0, 0}, exp_port: 1, exp_addr: 32'h304, exp_err: 1};
      vecs[6] = '{t: '{0, 1, 32'h0, 32'h308, 0, 0, 32'h7777_0006, 2'b00, 1, 1}, exp_port: 1, exp_addr: 32'h308, exp_err: 1};
      vecs[7] = '{t: '{0, 1, 32'h0, 32'h30C, 0, 0, 32'h8888_0007, 2'b00, 1, 0}, exp_port: 1, exp_addr: 32'h30C, exp_err: 0};
      vecs[8] = '{t: '{1, 0, 32'h403, 32'h0, 0, 0, 32'h9999_0008, 2'b11, 1, 0}, exp_port: 0, exp_addr: 32'h400, exp_err: 1};
      vecs[9] = '{t: '{1, 0, 32'h500, 32'h0, 5, 7, 32'hAAAA_0009, 2'b00, 1, 0}, exp_port: 0, exp_addr: 32'h500, exp_err: 0};
      for (int i = 0; i < 10; i++) begin
         run_txn(vecs[i].t, r);
         chk($sformatf("vec%0d_port", i), r.port, vecs[i].exp_port);
         chk($sformatf("vec%0d_addr", i), r.addr, vecs[i].exp_addr);
         chk($sformatf("vec%0d_data", i), r.data, vecs[i].t.rd);
         chk($sformatf("vec%0d_err", i), r.err, vecs[i].exp_err);
      end

      // Randomised traffic against the reference model
      apply_reset();
      for (int i = 0; i < 40; i++) begin
         int p;
         t.r0  = 1'($urandom);
         t.r1  = t.r0 ? 1'($urandom) : 1'b1;
         t.a0  = $urandom;
         t.a1  = $urandom;
         t.arw = ($urandom_range(0, 7) == 0) ? 5 : $urandom_range(0, 3);
         t.rw  = $urandom_range(0, 3);
         t.rd  = $urandom;
         t.rr  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         t.rl  = ($urandom_range(0, 7) != 0);
         t.rb  = ($urandom_range(0, 7) == 0);
         p = model_pick(t.r0, t.r1);
         run_txn(t, r);
         if (!r.ok) continue;
         chk($sformatf("rnd%0d_port", i), r.port, p);
         chk($sformatf("rnd%0d_addr", i), r.addr, ((p == 1) ? t.a1 : t.a0) & ~32'h3);
         chk($sformatf("rnd%0d_err", i), r.err, model_err(t));
         m_data[p] = t.rd;
         m_last    = p;
         chk($sformatf("rnd%0d_data", i), {r.d0, r.d1}, {m_data[0], m_data[1]});
      end

      // Reset while waiting for R: the beat is lost and nothing is reported
      REQ0_VALID    = 1'b1;
      REQ1_VALID    = 1'b0;
      REQ0_ADDR     = 32'h0000_0800;
      M_AXI_ARREADY = 1'b0;
      k = 0;
      do begin @(negedge ACLK); k++; end while (!M_AXI_ARVALID && k < 10);
      M_AXI_ARREADY = 1'b1;
      @(negedge ACLK);
      M_AXI_ARREADY = 1'b0;
      chk("mid_r_entered", {M_AXI_ARVALID, M_AXI_RREADY}, 2'b01);
      ARESETN      = 1'b0;
      REQ0_VALID   = 1'b0;
      M_AXI_RVALID = 1'b1;
      M_AXI_RDATA  = 32'hBAD0_BAD0;
      M_AXI_RRESP  = 2'b00;
      M_AXI_RLAST  = 1'b1;
      M_AXI_RID    = '0;
      #1;
      chk("mid_reset", {M_AXI_ARVALID, M_AXI_RREADY, BUSY, RSP0_VALID, RSP1_VALID}, 5'b00000);
      @(negedge ACLK);
      @(negedge ACLK);
      M_AXI_RVALID = 1'b0;
      ARESETN      = 1'b1;
      model_reset();
      @(negedge ACLK);
      chk("post_reset_quiet", {RSP0_VALID, RSP1_VALID, BUSY, RSP0_DATA, RSP1_DATA}, 67'd0);
      t = '{r0: 0, r1: 1, a0: 32'h0, a1: 32'h0000_0C04, arw: 1, rw: 1,
            rd: 32'h1234_5678, rr: 2'b00, rl: 1, rb: 0};
      run_txn(t, r);
      chk("after_reset_port", r.port, 1);
      chk("after_reset_data", {r.data, 31'd0, r.err}, {32'h1234_5678, 32'd0});
      m_data[1] = t.rd;
      m_last    = 1;
      t = '{r0: 1, r1: 1, a0: 32'h0000_0D00, a1: 32'h0000_0E00, arw: 0, rw: 0,
            rd: 32'hCAFE_F00D, rr: 2'b00, rl: 1, rb: 0};
      run_txn(t, r);
      chk("after_reset_rr", r.port, model_pick(1, 1));
      chk("after_reset_hold", {r.d0, r.d1}, {32'hCAFE_F00D, m_data[1]});
      REQ0_VALID = 1'b0;
      REQ1_VALID = 1'b0;
      @(negedge ACLK);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
